// File: rtl/han_carlson_adder_32b.sv
// Purpose : exact 32-bit unsigned adder, Han-Carlson parallel-prefix carry network, 33-bit registered sum.
// Latency : 2 clocks with HC_INPUT_REG_EN defined (inputs and sum registered), 1 clock otherwise (sum only).
// Backpressure: none; a new operand pair is accepted every cycle, no handshake.
//
// Ports:
//   s   [32:0] out  registered sum, s[32] is the carry-out
//   x   [31:0] in   operand A, unsigned
//   y   [31:0] in   operand B, unsigned
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset, 0 clears every register
//
// Build option: define HC_INPUT_REG_EN to register x/y before the prefix network.
module han_carlson_adder_32b (
  output logic [32:0] s,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        clk,
  input  logic        rst
);

  logic [31:0] xr;
  logic [31:0] yr;

`ifdef HC_INPUT_REG_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      xr <= '0;
      yr <= '0;
    end else begin
      xr <= x;
      yr <= y;
    end
  end
`else
  assign xr = x;
  assign yr = y;
`endif

  // Prefix levels: index 0 is bitwise generate/propagate, 1..5 are the
  // Kogge-Stone levels over odd positions, 6 fills in the even positions.
  logic [31:0] gk [0:6];
  logic [31:0] pk [0:6];
  logic [31:0] c;
  logic [31:0] sum;

  always_comb begin
    gk[0] = xr & yr;
    pk[0] = xr ^ yr;
    for (int l = 1; l <= 5; l++) begin
      gk[l] = gk[l-1];
      pk[l] = pk[l-1];
      // Only odd positions move; at span 1 each odd bit absorbs its even
      // neighbour, after that odd bits combine with odd bits span away.
      for (int i = 1; i < 32; i += 2) begin
        if (i >= (1 << (l - 1))) begin
          gk[l][i] = gk[l-1][i] | (pk[l-1][i] & gk[l-1][i - (1 << (l - 1))]);
          pk[l][i] = pk[l-1][i] & pk[l-1][i - (1 << (l - 1))];
        end
      end
    end
    // After level 5 every odd bit holds the group generate of [i:0]; each
    // even bit above 0 needs one more step with its odd neighbour below.
    gk[6] = gk[5];
    pk[6] = pk[5];
    for (int i = 2; i < 32; i += 2) begin
      gk[6][i] = gk[5][i] | (pk[5][i] & gk[5][i-1]);
      pk[6][i] = pk[5][i] & pk[5][i-1];
    end
    c   = gk[6];
    // No carry-in, so bit 0 sees c[-1] = 0.
    sum = pk[0] ^ {c[30:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s <= '0;
    end else begin
      s <= {c[31], sum};
    end
  end

endmodule

// File: tb/tb_han_carlson_adder_32b.sv
module tb_han_carlson_adder_32b;

`ifdef HC_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic [31:0] y;
  logic [32:0] s;

  int n_applied;
  int n_miscompare;

  han_carlson_adder_32b dut (
    .s   (s),
    .x   (x),
    .y   (y),
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] sum;
  } vec_t;

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    n_applied++;
    if (got !== want) begin
      n_miscompare++;
      $display("FAIL %s: s=0x%09h expected 0x%09h", name, got, want);
    end
  endtask

  // Hold a pair for two edges, then sample; valid for either build latency.
  task automatic apply_hold(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [32:0] want);
    @(negedge clk);
    x = a;
    y = b;
    repeat (2) @(posedge clk);
    #1;
    check(name, s, want);
  endtask

  // New pair every cycle; each output is compared LAT edges after its pair.
  task automatic run_stream(input string name, input int n, input bit rnd, input int base);
    logic [32:0] exp_q[$];
    logic [31:0] a;
    logic [31:0] b;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rnd) begin
        a = $urandom;
        b = $urandom;
      end else begin
        a = base + k * 32'h1111_1111;
        b = 32'hF000_0000 - k * 32'h0FED_CBA9;
      end
      x = a;
      y = b;
      exp_q.push_back({1'b0, a} + {1'b0, b});
      @(posedge clk);
      #1;
      if (exp_q.size() == LAT) check(name, s, exp_q.pop_front());
    end
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      check(name, s, exp_q.pop_front());
    end
  endtask

  initial begin
    vec_t vecs[10];
    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 33'h0_0000_000C};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000};
    vecs[5] = '{32'hAAAA_AAAA, 32'h5555_5555, 33'h0_FFFF_FFFF};
    vecs[6] = '{32'hAAAA_AAAB, 32'h5555_5555, 33'h1_0000_0000};
    vecs[7] = '{32'h1234_5678, 32'h8765_4321, 33'h0_9999_9999};
    vecs[8] = '{32'h7FFF_FFFF, 32'h0000_0001, 33'h0_8000_0000};
    vecs[9] = '{32'hDEAD_BEEF, 32'h2152_4111, 33'h1_0000_0000};

    n_applied    = 0;
    n_miscompare = 0;
    rst = 1'b0;
    x   = '0;
    y   = '0;

    // Reset held for two edges; all registers read zero.
    repeat (2) @(posedge clk);
    #1;
    check("reset", s, 33'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_release", s, 33'h0);

    foreach (vecs[i]) begin
      apply_hold($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sum);
    end

    run_stream("stream10", 10, 1'b0, 32'h0123_4567);

    // Mid-stream reset: load non-trivial pairs, then reset while they are in flight.
    @(negedge clk);
    x = 32'hFFFF_FFFF;
    y = 32'h0000_0003;
    @(negedge clk);
    x = 32'h1357_9BDF;
    y = 32'hFEDC_BA98;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset", s, 33'h0);
    @(negedge clk);
    rst = 1'b1;

    run_stream("random", 2000, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
    $finish;
  end

endmodule
